ntt_bfly_pipe: RTL

Parametrised, pipelined Kyber butterfly engine. It serves both the forward NTT (Cooley-Tukey) and the inverse NTT (Gentleman-Sande) from one datapath, with a per-transaction mode bit. It processes LANES coefficient pairs per beat behind valid/ready handshakes and carries a sideband tag for write-back addressing. It sits between the polynomial RAM read port and the write-back logic of the NTT controller, and replaces the single-lane, inverse-only butterfly.

---
 rtl/kyber_pkg.sv | 39 +++
 rtl/ntt_bfly_pipe_if.sv | 31 +++
 rtl/bfly_lane.sv | 86 ++++++++
 rtl/ntt_bfly_pipe.sv | 78 +++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Kyber arithmetic shared by the butterfly datapath: field constants,
// mode encoding, coefficient type and the two modular reductions.
package kyber_pkg;

   localparam int                 Q         = 3329;
   localparam logic signed [15:0] QINV      = -16'sd3327;
   localparam int                 BARRETT_V = 20159;

   typedef logic signed [15:0] coeff_t;

   typedef enum logic {
      MODE_FWD = 1'b0,
      MODE_INV = 1'b1
   } mode_e;

   // Montgomery reduction of a 32-bit product; result lies in (-Q,Q).
   function automatic coeff_t mont_reduce(input logic signed [31:0] p);
      int     m;
      coeff_t u;
      int     r;
      m = int'(p) * int'(QINV);
      u = coeff_t'(m);
      r = int'(p) - int'(u) * Q;
      return coeff_t'(r >>> 16);
   endfunction

   // Montgomery multiply: x*y*2^-16 mod Q.
   function automatic coeff_t fqmul(input coeff_t x, input coeff_t y);
      return mont_reduce(int'(x) * int'(y));
   endfunction

   // Barrett reduction to a small signed representative.
   function automatic coeff_t barrett(input coeff_t x);
      int t;
      t = (BARRETT_V * int'(x) + (1 << 25)) >>> 26;
      return coeff_t'(int'(x) - t * Q);
   endfunction

endpackage

// File: rtl/ntt_bfly_pipe_if.sv
// Handshake and data bus of the butterfly engine. The engine is the
// slave; the read-port/write-back side is the master.
interface ntt_bfly_pipe_if #(
   parameter int LANES = 2,
   parameter int TAG_W = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_mode;
   logic [TAG_W-1:0]      in_tag;
   logic [16*LANES-1:0]   in_a;
   logic [16*LANES-1:0]   in_b;
   logic [16*LANES-1:0]   in_zeta;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_mode;
   logic [TAG_W-1:0]      out_tag;
   logic [16*LANES-1:0]   out_lo;
   logic [16*LANES-1:0]   out_hi;
   logic                  busy;

   modport slave (
      input  in_valid, in_mode, in_tag, in_a, in_b, in_zeta, out_ready,
      output in_ready, out_valid, out_mode, out_tag, out_lo, out_hi, busy
   );

   modport master (
      output in_valid, in_mode, in_tag, in_a, in_b, in_zeta, out_ready,
      input  in_ready, out_valid, out_mode, out_tag, out_lo, out_hi, busy
   );
endinterface

// File: rtl/bfly_lane.sv
// Single-lane S1..S4 butterfly datapath. Control (valid, mode, tag) lives
// in the top level; this lane only holds data and advances on en_i.
module bfly_lane
   import kyber_pkg::*;
#(
   parameter bit FWD_REDUCE = 1'b0
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   en_i,
   input  mode_e  mode_s1_i,
   input  mode_e  mode_s3_i,
   input  coeff_t a_i,
   input  coeff_t b_i,
   input  coeff_t zeta_i,
   output coeff_t lo_o,
   output coeff_t hi_o
);

   coeff_t             a_q, b_q, z_q;
   logic signed [31:0] prod_q, prod_d;
   coeff_t             c2_q, c2_d;
   coeff_t             t3_q, t3_d;
   coeff_t             c3_q;
   coeff_t             lo_q, lo_d, hi_q, hi_d;
   coeff_t             sum1, diff1, mul1;
   coeff_t             sum4, diff4;

   // S1 combinational: sum/diff and multiplicand/carry selection by mode
   always_comb begin
      sum1  = a_q + b_q;
      diff1 = b_q - a_q;
      mul1  = (mode_s1_i == MODE_INV) ? diff1 : b_q;
      c2_d  = (mode_s1_i == MODE_INV) ? sum1 : a_q;
      prod_d = int'(z_q) * int'(mul1);
   end

   // S3 combinational: Montgomery reduction of the registered product
   always_comb begin
      t3_d = mont_reduce(prod_q);
   end

   // S4 combinational: final add/sub (forward) or Barrett of the sum (inverse)
   always_comb begin
      sum4  = c3_q + t3_q;
      diff4 = c3_q - t3_q;
      lo_d  = sum4;
      hi_d  = diff4;
      if (mode_s3_i == MODE_INV) begin
         lo_d = barrett(c3_q);
         hi_d = t3_q;
      end else if (FWD_REDUCE) begin
         lo_d = barrett(sum4);
         hi_d = barrett(diff4);
      end
   end

   // Stage registers; all hold together while the pipe is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         z_q    <= '0;
         prod_q <= '0;
         c2_q   <= '0;
         t3_q   <= '0;
         c3_q   <= '0;
         lo_q   <= '0;
         hi_q   <= '0;
      end else if (en_i) begin
         a_q    <= a_i;
         b_q    <= b_i;
         z_q    <= zeta_i;
         prod_q <= prod_d;
         c2_q   <= c2_d;
         t3_q   <= t3_d;
         c3_q   <= c2_q;
         lo_q   <= lo_d;
         hi_q   <= hi_d;
      end
   end

   assign lo_o = lo_q;
   assign hi_o = hi_q;

endmodule

// File: rtl/ntt_bfly_pipe.sv
// Multi-lane Kyber butterfly engine (forward CT / inverse GS per beat).
// Owns the four stage valid bits, the global stall and the mode/tag pipe;
// the per-lane arithmetic lives in bfly_lane.
module ntt_bfly_pipe
   import kyber_pkg::*;
#(
   parameter int LANES      = 2,
   parameter int TAG_W      = 8,
   parameter bit FWD_REDUCE = 1'b0
) (
   input logic            clk,
   input logic            rst_n,
   ntt_bfly_pipe_if.slave bus
);

   logic [3:0]       vld_q, vld_d;
   mode_e            mode_q [4];
   mode_e            mode_d [4];
   logic [TAG_W-1:0] tag_q  [4];
   logic [TAG_W-1:0] tag_d  [4];
   logic             stall, en, acc;

   assign stall = vld_q[3] & ~bus.out_ready;
   assign en    = ~stall;
   assign acc   = bus.in_valid & en;

   // Next-state of the control pipe: shift valid, mode and tag one stage
   always_comb begin
      vld_d     = {vld_q[2:0], acc};
      mode_d[0] = mode_e'(bus.in_mode);
      tag_d[0]  = bus.in_tag;
      for (int unsigned i = 1; i < 4; i++) begin
         mode_d[i] = mode_q[i-1];
         tag_d[i]  = tag_q[i-1];
      end
   end

   // Control pipe registers; hold on stall, cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            mode_q[i] <= MODE_FWD;
            tag_q[i]  <= '0;
         end
      end else if (en) begin
         vld_q <= vld_d;
         for (int unsigned i = 0; i < 4; i++) begin
            mode_q[i] <= mode_d[i];
            tag_q[i]  <= tag_d[i];
         end
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      bfly_lane #(
         .FWD_REDUCE(FWD_REDUCE)
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .en_i      (en),
         .mode_s1_i (mode_q[0]),
         .mode_s3_i (mode_q[2]),
         .a_i       (bus.in_a[16*k +: 16]),
         .b_i       (bus.in_b[16*k +: 16]),
         .zeta_i    (bus.in_zeta[16*k +: 16]),
         .lo_o      (bus.out_lo[16*k +: 16]),
         .hi_o      (bus.out_hi[16*k +: 16])
      );
   end

   assign bus.in_ready  = en;
   assign bus.out_valid = vld_q[3];
   assign bus.out_mode  = mode_q[3];
   assign bus.out_tag   = tag_q[3];
   assign bus.busy      = |vld_q;

endmodule
